fc_neuron_mac: RTL and testbench
================================

// Module: fc_neuron_mac
// PURPOSE
//   Signed int8 x int8 multiply-accumulate engine for one fully-connected neuron.
//   - Seeds a 32-bit accumulator with the neuron bias.
//   - Consumes IN_LEN activation/weight pairs over a valid/ready stream.
//   - Presents the 32-bit sum to the downstream FC quantization stage (int32 -> int8)
//     and holds it until accepted.
//   - Sits directly upstream of the quantizer; one result per neuron.
// PARAMETERS
//   IN_LEN  64  number of activation/weight pairs per neuron (>=1)
//   ACC_W   32  accumulator / result width (bits)
// PORTS
//   clk        in   1      clock, rising edge
//   rstn       in   1      asynchronous reset, active-low
//   clr        in   1      synchronous soft clear; aborts any operation
//   start      in   1      begin neuron; bias_in sampled same cycle
//   bias_in    in   ACC_W  signed bias, initial accumulator value
//   in_valid   in   1      act_in/wgt_in valid
//   in_ready   out  1      engine accepts a pair this cycle
//   act_in     in   8      signed activation
//   wgt_in     in   8      signed weight
//   out_valid  out  1      acc_out holds a final result
//   out_ready  in   1      downstream accepts result
//   acc_out    out  ACC_W  signed accumulated result
//   busy       out  1      high in ACC and OUT states
//   ovf        out  1      sticky overflow flag for current neuron
// BEHAVIOUR
//   Reset (rstn=0, async):
//   - State IDLE; acc=0; count=0.
//   - in_ready=0, out_valid=0, acc_out=0, busy=0, ovf=0.
//   States:
//   - IDLE: in_ready=0, out_valid=0.
//     start=1 -> acc<=bias_in, count<=0, ovf<=0, go ACC.
//   - ACC: in_ready=1.
//     - Handshake = in_valid & in_ready.
//     - Per handshake: acc <= acc + sext(act_in*wgt_in). Product is 16-bit signed, sign-extended to ACC_W.
//     - Per handshake: count <= count+1.
//     - in_valid=0 cycles are bubbles: no update, count held.
//     - Handshake with count==IN_LEN-1 -> acc_out<=updated sum, go OUT.
//       out_valid rises the next cycle (1-cycle latency after last pair).
//     - start in ACC is ignored.
//   - OUT: out_valid=1, in_ready=0; acc_out and ovf held stable.
//     - out_ready=1 -> out_valid drops next cycle, go IDLE.
//     - out_ready=1 and start=1 same cycle -> result retired and new neuron seeded; go ACC directly (back-to-back).
//     - start without out_ready is ignored.
//   Minimum latency: start to out_valid = IN_LEN+1 cycles with no bubbles.
//   IN_LEN=1: first handshake goes straight to OUT.
//   count: width $clog2(IN_LEN+1); never wraps, since transition to OUT occurs at IN_LEN-1.
//   clr=1 (any state, priority over all else):
//   - Next cycle: IDLE, out_valid=0, in_ready=0, busy=0, acc=0, ovf=0.
//   - Any pending result is discarded.
//   rstn mid-operation: immediate return to reset values; the partial sum is lost.
//   acc_out retains the last result after retirement until overwritten; it is only meaningful while out_valid=1.
// CONFIGURATION
//   FC_MAC_SATURATE_EN defined:
//   - Each accumulate saturates to signed ACC_W limits (0x7FFFFFFF / 0x80000000 for 32).
//   - ovf set sticky on any clamp; cleared on start/clr/rstn.
//   FC_MAC_SATURATE_EN undefined:
//   - Accumulation wraps modulo 2^ACC_W.
//   - ovf tied 0.
// TESTING
//   1 IN_LEN=4, bias=0x10, act {1,2,3,4}, wgt {1,1,1,1}, no bubbles
//     -> out_valid 5 cycles after start, acc_out=0x0000001A.
//   2 IN_LEN=4, bias=-1, act=-128, wgt=-128 x4
//     -> acc_out=0x0000FFFF, ovf=0.
//   3 Case 1 with out_ready=0 for 10 cycles and start pulsed during OUT
//     -> out_valid/acc_out stable, in_ready=0, start ignored; retires on out_ready.
//   4 Case 1 with in_valid low every other cycle
//     -> acc_out=0x1A, 4 handshakes counted, out_valid 1 cycle after 4th pair.
//   5 IN_LEN=4, bias=0x7FFFFF00, act=127, wgt=127 x4
//     -> EN: acc_out=0x7FFFFFFF, ovf=1; not EN: acc_out=0x8000FB04, ovf=0.
//   6 clr after 2 pairs of case 1, then fresh start of case 1
//     -> in_ready=0, busy=0 after clr; second run acc_out=0x1A.
//      Repeat with rstn pulse instead of clr -> identical result.

Source files
------------

// File: rtl/fc_neuron_mac.sv
// rtl/fc_neuron_mac.sv - signed int8 x int8 multiply-accumulate engine for one FC neuron
//
// Purpose:
//   Seeds an ACC_W-bit accumulator with the neuron bias, consumes IN_LEN
//   activation/weight pairs over a valid/ready stream, then presents the sum
//   to the downstream quantizer and holds it until accepted.
//   Optional macro FC_MAC_SATURATE_EN: each accumulate saturates to the signed
//   ACC_W limits and sets the sticky ovf flag; otherwise it wraps and ovf stays 0.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   clr                  synchronous soft clear, aborts any operation
//   start, bias_in       begin a neuron; bias_in seeds the accumulator
//   in_valid/in_ready    input pair handshake for act_in/wgt_in (signed int8)
//   out_valid/out_ready  result handshake for acc_out (signed ACC_W)
//   busy                 high while accumulating or holding a result
//   ovf                  sticky overflow flag for the current neuron

module fc_neuron_mac #(
  parameter int IN_LEN = 64,
  parameter int ACC_W  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             start,
  input  logic [ACC_W-1:0] bias_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       act_in,
  input  logic [7:0]       wgt_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy,
  output logic             ovf
);

  localparam int CNT_W = $clog2(IN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             ovf_q, ovf_d;

  logic signed [15:0] prod;
  logic [ACC_W-1:0]   acc_next;
  logic               clamp;

  assign prod = $signed(act_in) * $signed(wgt_in);

`ifdef FC_MAC_SATURATE_EN
  // One guard bit: the sum overflowed when the guard and the top bit disagree;
  // the guard then carries the true sign, selecting which limit to clamp to.
  logic [ACC_W:0] sum_wide;
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W - 15){prod[15]}}, prod};
  assign clamp    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  always_comb begin
    acc_next = sum_wide[ACC_W-1:0];
    if (clamp) begin
      acc_next = sum_wide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                 : {1'b0, {(ACC_W - 1){1'b1}}};
    end
  end
`else
  assign acc_next = acc_q + {{(ACC_W - 16){prod[15]}}, prod};
  assign clamp    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    acc_out_d = acc_out_q;
    ovf_d     = ovf_q;
    if (clr) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ACC;
            acc_d   = bias_in;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        ST_ACC: begin
          if (in_valid) begin
            acc_d   = acc_next;
            count_d = count_q + CNT_W'(1);
            ovf_d   = ovf_q | clamp;
            if (count_q == LAST_IDX) begin
              acc_out_d = acc_next;
              state_d   = ST_OUT;
            end
          end
        end
        ST_OUT: begin
          // start only counts when the result retires in the same cycle
          if (out_ready) begin
            if (start) begin
              state_d = ST_ACC;
              acc_d   = bias_in;
              count_d = '0;
              ovf_d   = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      acc_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      acc_out_q <= acc_out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q == ST_ACC) || (state_q == ST_OUT);
  assign acc_out   = acc_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fc_neuron_mac.sv
// tb/tb_fc_neuron_mac.sv - directed self-checking bench for fc_neuron_mac

module tb_fc_neuron_mac;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] bias_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  act_in = '0;
  logic [7:0]  wgt_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] acc_out;
  logic        busy;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  fc_neuron_mac #(.IN_LEN(4), .ACC_W(32)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .start(start), .bias_in(bias_in),
    .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .wgt_in(wgt_in),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Feeds four pairs; optional bubble after each pair except the last.
  task automatic feed4(input logic [7:0] a0, a1, a2, a3,
                       input logic [7:0] w0, w1, w2, w3, input bit bubbles);
    logic [7:0] a [4];
    logic [7:0] w [4];
    a = '{a0, a1, a2, a3};
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      act_in   = a[i];
      wgt_in   = w[i];
      chk("no_out_before_last", {31'd0, out_valid}, 32'd0);
      tick();
      if (bubbles && i < 3) begin
        in_valid = 1'b0;
        act_in   = 8'h55;
        wgt_in   = 8'h55;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] b);
    start   = 1'b1;
    bias_in = b;
    tick();
    start   = 1'b0;
    bias_in = 32'hDEAD_BEEF;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("retire_out_valid", {31'd0, out_valid}, 32'd0);
    chk("retire_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // reset values
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_acc_out", acc_out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // case 1: plain run, out_valid exactly after the 4th pair
    do_start(32'h10);
    chk("c1_busy", {31'd0, busy}, 32'd1);
    chk("c1_in_ready", {31'd0, in_ready}, 32'd1);
    feed4(8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    chk("c1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("c1_acc_out", acc_out, 32'h0000_001A);
    chk("c1_in_ready_out", {31'd0, in_ready}, 32'd0);
    retire();

    // case 2: largest positive products
    do_start(32'hFFFF_FFFF);
    feed4(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 1'b0);
    chk("c2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("c2_acc_out", acc_out, 32'h0000_FFFF);
    chk("c2_ovf", {31'd0, ovf}, 32'd0);
    retire();

    // case 3: backpressure with a start pulse that must be ignored
    do_start(32'h10);
    feed4(8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      start   = (i == 3);
      bias_in = 32'h1234_5678;
      in_valid = 1'b1;
      tick();
      chk("c3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("c3_hold_acc", acc_out, 32'h0000_001A);
      chk("c3_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    start = 1'b0;
    in_valid = 1'b0;
    retire();

    // case 4: bubbles between pairs
    do_start(32'h10);
    feed4(8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
    chk("c4_out_valid", {31'd0, out_valid}, 32'd1);
    chk("c4_acc_out", acc_out, 32'h0000_001A);

    // back-to-back: retire and start together, go straight to accumulating
    out_ready = 1'b1;
    start     = 1'b1;
    bias_in   = 32'h7FFF_FF00;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd0);

    // case 5: overflow of 0x7FFFFF00 + 4*16129
    feed4(8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 1'b0);
    chk("c5_out_valid", {31'd0, out_valid}, 32'd1);
`ifdef FC_MAC_SATURATE_EN
    chk("c5_acc_out", acc_out, 32'h7FFF_FFFF);
    chk("c5_ovf", {31'd0, ovf}, 32'd1);
`else
    chk("c5_acc_out", acc_out, 32'h8000_FB04);
    chk("c5_ovf", {31'd0, ovf}, 32'd0);
`endif
    retire();
    do_start(32'h10);
    chk("c5_ovf_cleared_on_start", {31'd0, ovf}, 32'd0);

    // case 6a: clr after two pairs, then a fresh run
    in_valid = 1'b1;
    act_in = 8'd1; wgt_in = 8'd1; tick();
    act_in = 8'd2; tick();
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("c6_clr_in_ready", {31'd0, in_ready}, 32'd0);
    chk("c6_clr_busy", {31'd0, busy}, 32'd0);
    chk("c6_clr_out_valid", {31'd0, out_valid}, 32'd0);
    do_start(32'h10);
    feed4(8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    chk("c6_clr_acc_out", acc_out, 32'h0000_001A);
    retire();

    // case 6b: async reset mid-run, then a fresh run
    do_start(32'h10);
    in_valid = 1'b1;
    act_in = 8'd1; wgt_in = 8'd1; tick();
    act_in = 8'd2; tick();
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("c6_rst_busy", {31'd0, busy}, 32'd0);
    chk("c6_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("c6_rst_acc_out", acc_out, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    do_start(32'h10);
    feed4(8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    chk("c6_rst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("c6_rst_acc_out2", acc_out, 32'h0000_001A);
    retire();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
